mult_share_arbiter: RTL and testbench

Sequencing controller that shares one iterative 8-step multiplier datapath between two requesters. It accepts operand pairs over valid/ready handshakes and arbitrates round-robin. It issues a one-cycle start to the multiplier, waits for its done pulse, and returns the product to the granted requester over a response handshake. It sits between client logic and the multiplier/control unit pair; exactly one multiplication is in flight at a time.

---
 rtl/mult_ctrl_pkg.sv | 22 ++
 rtl/rr_arbiter2.sv | 47 ++++
 rtl/mult_share_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_mult_share_arbiter.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mult_ctrl_pkg
//
// Shared definitions for the multiplier-sharing controller:
//   - state_e        : sequencing FSM states
//   - DefaultWidth   : default operand width (product is twice this)
//   - DefaultTimeout : default watchdog limit, in BUSY cycles
// -----------------------------------------------------------------------------
package mult_ctrl_pkg;

    localparam int unsigned DefaultWidth   = 8;
    localparam int unsigned DefaultTimeout = 16;

    // IDLE -> ISSUE -> BUSY -> RESPOND -> IDLE
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StIssue   = 2'd1,
        StBusy    = 2'd2,
        StRespond = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
//
// Two-requester round-robin grant logic. The grant is purely combinational
// from the request vector and the stored last-grant pointer. The pointer
// only moves when the owner of a grant finishes, signalled on update_i.
//
// Ports:
//   clk_i        : clock, rising edge
//   rst_i        : asynchronous active-high reset (pointer -> 1)
//   req_i[1:0]   : request vector, bit n = requester n
//   update_i     : finished operation, load the pointer this edge
//   update_id_i  : requester that owned the finished operation
//   gnt_o[1:0]   : one-hot grant, zero when nobody requests
// -----------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       update_i,
    input  logic       update_id_i,
    output logic [1:0] gnt_o
);

    // Resets to 1 so requester 0 wins the first tie.
    logic last_grant_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q <= 1'b1;
        end else if (update_i) begin
            last_grant_q <= update_id_i;
        end
    end

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            // Tie: the requester that was not served last goes first.
            2'b11:   gnt_o = last_grant_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// -----------------------------------------------------------------------------
// mult_share_arbiter
//
// Shares one iterative multiplier between two requesters. Operand pairs are
// accepted over valid/ready, one at a time, with round-robin arbitration.
// The controller pulses mult_start for one cycle, waits for mult_done and
// returns the product to the granted requester over a response handshake.
//
// Optional build macro:
//   MULT_WATCHDOG_EN : bound the BUSY wait to TIMEOUT cycles. On expiry the
//                      response carries product 0 and the sticky mult_timeout
//                      flag is set. Without it BUSY waits indefinitely.
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   req0_*/req1_*            : operand request handshakes (valid/ready, a, b)
//   rsp0_*/rsp1_*            : response handshakes (valid/ready)
//   rsp_product              : shared result bus, valid with either rsp*_valid
//   mult_start               : one-cycle start pulse to the multiplier
//   mult_a, mult_b           : latched operands for the multiplier
//   mult_done, mult_product  : multiplier completion pulse and result
//   busy                     : operation in progress (state != IDLE)
//   grant_id                 : requester owning the current operation
//   mult_timeout             : sticky watchdog flag
// -----------------------------------------------------------------------------
module mult_share_arbiter
    import mult_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH   = DefaultWidth,
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,

    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [2*WIDTH-1:0]   rsp_product,

    output logic                 mult_start,
    output logic [WIDTH-1:0]     mult_a,
    output logic [WIDTH-1:0]     mult_b,
    input  logic                 mult_done,
    input  logic [2*WIDTH-1:0]   mult_product,

    output logic                 busy,
    output logic                 grant_id,
    output logic                 mult_timeout
);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_e               state_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [2*WIDTH-1:0]   product_q;
    logic                 grant_q;
    logic                 start_q;

`ifdef MULT_WATCHDOG_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0]      wd_cnt_q;
    logic                 timeout_q;
    logic                 wd_expired;

    // Counter holds the number of BUSY cycles already spent without done.
    assign wd_expired   = (wd_cnt_q == CntW'(TIMEOUT - 1));
    assign mult_timeout = timeout_q;
`else
    assign mult_timeout = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic [1:0]           arb_gnt;
    logic                 is_idle;
    logic                 accept;
    logic                 win_id;
    logic [WIDTH-1:0]     win_a;
    logic [WIDTH-1:0]     win_b;
    logic                 rsp_ready_sel;
    logic                 rsp_fire;

    assign is_idle = (state_q == StIdle);

    // Only the owner's response ready matters; the other side is ignored.
    assign rsp_ready_sel = grant_q ? rsp1_ready : rsp0_ready;
    assign rsp_fire      = (state_q == StRespond) && rsp_ready_sel;

    rr_arbiter2 u_arb (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       ({req1_valid, req0_valid}),
        .update_i    (rsp_fire),
        .update_id_i (grant_q),
        .gnt_o       (arb_gnt)
    );

    // Ready is offered only to the winner and only while idle. It is also held
    // low while reset is asserted so nothing appears accepted during reset.
    assign req0_ready = is_idle && !rst && arb_gnt[0];
    assign req1_ready = is_idle && !rst && arb_gnt[1];

    assign accept = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign win_id = arb_gnt[1];
    assign win_a  = win_id ? req1_a : req0_a;
    assign win_b  = win_id ? req1_b : req0_b;

    // -------------------------------------------------------------------------
    // Sequencing FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            product_q <= '0;
            grant_q   <= 1'b0;
            start_q   <= 1'b0;
`ifdef MULT_WATCHDOG_EN
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        a_q     <= win_a;
                        b_q     <= win_b;
                        grant_q <= win_id;
                        start_q <= 1'b1;
                        state_q <= StIssue;
                    end
                end

                StIssue: begin
                    // A done pulse here is deliberately not captured.
                    start_q <= 1'b0;
`ifdef MULT_WATCHDOG_EN
                    wd_cnt_q <= '0;
`endif
                    state_q <= StBusy;
                end

                StBusy: begin
                    // Done has priority over an expiring watchdog.
                    if (mult_done) begin
                        product_q <= mult_product;
                        state_q   <= StRespond;
                    end
`ifdef MULT_WATCHDOG_EN
                    else if (wd_expired) begin
                        product_q <= '0;
                        timeout_q <= 1'b1;
                        state_q   <= StRespond;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + CntW'(1);
                    end
`endif
                end

                StRespond: begin
                    // No grant is made in the exit cycle; arbitration resumes
                    // from IDLE on the following cycle.
                    if (rsp_ready_sel) begin
                        state_q <= StIdle;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs, all decoded from registered state
    // -------------------------------------------------------------------------
    assign mult_start  = start_q;
    assign mult_a      = a_q;
    assign mult_b      = b_q;
    assign rsp_product = product_q;
    assign grant_id    = grant_q;
    assign busy        = !is_idle;
    assign rsp0_valid  = (state_q == StRespond) && !grant_q;
    assign rsp1_valid  = (state_q == StRespond) && grant_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_share_arbiter
//
// Self-checking bench for mult_share_arbiter. A behavioural multiplier answers
// mult_start after a programmable delay D; expectations come from a small
// model: product = a*b, ties go to the requester not served last, single
// requests always win, accept-to-response latency is D+2 cycles.
// Watchdog scenarios are compiled in when MULT_WATCHDOG_EN is defined.
// -----------------------------------------------------------------------------
module tb_mult_share_arbiter;

    localparam int W  = 8;
    localparam int TO = 16;

    logic            clk;
    logic            rst;
    logic            req0_valid, req1_valid;
    logic            req0_ready, req1_ready;
    logic [W-1:0]    req0_a, req0_b, req1_a, req1_b;
    logic            rsp0_valid, rsp1_valid;
    logic            rsp0_ready, rsp1_ready;
    logic [2*W-1:0]  rsp_product;
    logic            mult_start;
    logic [W-1:0]    mult_a, mult_b;
    logic            mult_done;
    logic [2*W-1:0]  mult_product;
    logic            busy;
    logic            grant_id;
    logic            mult_timeout;

    int total = 0;
    int bad   = 0;

    // Multiplier model controls
    int mult_d    = 4;
    bit mult_hang = 0;
    int mcnt;

    // Reference model state: who was served last
    bit exp_last = 1;

    mult_share_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .rsp0_valid   (rsp0_valid),
        .rsp0_ready   (rsp0_ready),
        .rsp1_valid   (rsp1_valid),
        .rsp1_ready   (rsp1_ready),
        .rsp_product  (rsp_product),
        .mult_start   (mult_start),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_done    (mult_done),
        .mult_product (mult_product),
        .busy         (busy),
        .grant_id     (grant_id),
        .mult_timeout (mult_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier: start seen in cycle S, done high in cycle S+D.
    initial begin
        mult_done    = 1'b0;
        mult_product = '0;
        mcnt         = 0;
        forever begin
            @(negedge clk);
            mult_done = 1'b0;
            if (rst) begin
                mcnt = 0;
            end else begin
                if (mcnt != 0) begin
                    mcnt--;
                    if (mcnt == 0 && !mult_hang) begin
                        mult_done    = 1'b1;
                        mult_product = 16'(mult_a) * 16'(mult_b);
                    end
                end
                if (mult_start) mcnt = mult_d;
            end
        end
    end

    // Model arbitration decision.
    function automatic int pick(bit v0, bit v1);
        if (v0 && v1) return exp_last ? 0 : 1;
        if (v1) return 1;
        return 0;
    endfunction

    function automatic logic [2*W-1:0] mul(logic [W-1:0] a, logic [W-1:0] b);
        return 16'(a) * 16'(b);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_last = 1'b1;
    endtask

    // Runs one transaction from an idle negedge with requests already driven.
    // Returns observations only; each test judges them.
    task automatic serve(input int stall, output int acc_id, output int lat,
                         output logic [2*W-1:0] prod, output int gid,
                         output int starts, output int glitches);
        acc_id = -1; lat = 0; prod = '0; gid = -1; starts = 0; glitches = 0;
        #1;
        if (req0_ready && req1_ready) glitches++;
        if (req0_valid && req0_ready) acc_id = 0;
        else if (req1_valid && req1_ready) acc_id = 1;
        if (acc_id < 0) return;
        @(posedge clk);
        #1;
        if (acc_id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (mult_start) starts++;
            if (rsp0_valid || rsp1_valid) break;
            if (req0_ready || req1_ready || !busy) glitches++;
        end
        if (!(rsp0_valid || rsp1_valid)) begin
            lat = -1;
            return;
        end
        gid  = int'(grant_id);
        prod = rsp_product;
        if ((rsp0_valid && rsp1_valid) || (rsp1_valid != grant_id)) glitches++;
        for (int i = 0; i < stall; i++) begin
            // The non-owner's ready must be ignored.
            if (gid == 0) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
            @(negedge clk);
            if (rsp_product !== prod || req0_ready || req1_ready) glitches++;
            if ((gid == 0) ? !rsp0_valid : !rsp1_valid) glitches++;
        end
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        @(negedge clk);
        if (busy || rsp0_valid || rsp1_valid) glitches++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 8'd1; req0_b = 8'd2; req1_a = 8'd3; req1_b = 8'd4;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            bad++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
        end
        total++;
        if ({rsp0_valid, rsp1_valid, mult_start, busy} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags: got %b want 0000",
                            {rsp0_valid, rsp1_valid, mult_start, busy});
        end
        total++;
        if (rsp_product !== 16'd0) begin
            bad++; $display("FAIL reset_product: got %0d want 0", rsp_product);
        end
        total++;
        if ({mult_a, mult_b} !== 16'd0) begin
            bad++; $display("FAIL reset_operands: got %h want 0000", {mult_a, mult_b});
        end
        total++;
        if ({grant_id, mult_timeout} !== 2'b00) begin
            bad++; $display("FAIL reset_grant_timeout: got %b want 00", {grant_id, mult_timeout});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
        exp_last = 1'b1;
        @(negedge clk);
        total++;
        if ({req0_ready, req1_ready, busy} !== 3'b000) begin
            bad++; $display("FAIL idle_no_request: got %b want 000",
                            {req0_ready, req1_ready, busy});
        end
    endtask

    task automatic test_single();
        int acc, lat, gid, st, gl;
        logic [2*W-1:0] prod;
        mult_d = 9;
        req0_a = 8'd13; req0_b = 8'd11; req0_valid = 1'b1;
        serve(0, acc, lat, prod, gid, st, gl);
        total++;
        if (acc !== 0) begin bad++; $display("FAIL single_accept: got %0d want 0", acc); end
        total++;
        if (lat !== 11) begin bad++; $display("FAIL single_latency: got %0d want 11", lat); end
        total++;
        if (prod !== 16'd143) begin bad++; $display("FAIL single_product: got %0d want 143", prod); end
        total++;
        if (st !== 1) begin bad++; $display("FAIL single_start_pulses: got %0d want 1", st); end
        total++;
        if (gl !== 0 || gid !== 0) begin
            bad++; $display("FAIL single_side: got glitches=%0d gid=%0d want 0 0", gl, gid);
        end
        exp_last = 1'b0;
    endtask

    task automatic test_tie();
        int acc, lat, gid, st, gl, want;
        logic [2*W-1:0] prod;
        do_reset();
        mult_d = int'($urandom_range(1, 12));
        req0_a = 8'd3; req0_b = 8'd4; req1_a = 8'd5; req1_b = 8'd6;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            want = pick(req0_valid, req1_valid);
            serve(0, acc, lat, prod, gid, st, gl);
            total++;
            if (acc !== want || gid !== want) begin
                bad++; $display("FAIL tie_grant[%0d]: got acc=%0d gid=%0d want %0d", k, acc, gid, want);
            end
            total++;
            if (prod !== ((want == 0) ? 16'd12 : 16'd30)) begin
                bad++; $display("FAIL tie_product[%0d]: got %0d want %0d", k, prod,
                                (want == 0) ? 12 : 30);
            end
            total++;
            if (lat !== mult_d + 2 || gl !== 0) begin
                bad++; $display("FAIL tie_timing[%0d]: got lat=%0d glitches=%0d want %0d 0",
                                k, lat, gl, mult_d + 2);
            end
            exp_last = want[0];
        end
    endtask

    task automatic test_alternate();
        int acc, lat, gid, st, gl, want;
        logic [2*W-1:0] prod, want_prod;
        for (int i = 0; i < 6; i++) begin
            if (!req0_valid) begin
                req0_a = W'($urandom); req0_b = W'($urandom); req0_valid = 1'b1;
            end
            if (!req1_valid) begin
                req1_a = W'($urandom); req1_b = W'($urandom); req1_valid = 1'b1;
            end
            mult_d    = int'($urandom_range(1, 8));
            want      = pick(1'b1, 1'b1);
            want_prod = (want == 0) ? mul(req0_a, req0_b) : mul(req1_a, req1_b);
            serve(0, acc, lat, prod, gid, st, gl);
            total++;
            if (acc !== want || acc !== (i % 2)) begin
                bad++; $display("FAIL alt_grant[%0d]: got %0d want %0d", i, acc, want);
            end
            total++;
            if (prod !== want_prod || gl !== 0) begin
                bad++; $display("FAIL alt_product[%0d]: got %0d glitches=%0d want %0d 0",
                                i, prod, gl, want_prod);
            end
            exp_last = want[0];
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_stall();
        int acc, lat, gid, st, gl;
        logic [2*W-1:0] prod, want_prod;
        mult_d = int'($urandom_range(1, 10));
        req1_a = W'($urandom); req1_b = W'($urandom); req1_valid = 1'b1;
        want_prod = mul(req1_a, req1_b);
        serve(5, acc, lat, prod, gid, st, gl);
        total++;
        if (acc !== 1 || gid !== 1) begin
            bad++; $display("FAIL stall_grant: got acc=%0d gid=%0d want 1", acc, gid);
        end
        total++;
        if (prod !== want_prod) begin
            bad++; $display("FAIL stall_product: got %0d want %0d", prod, want_prod);
        end
        total++;
        if (gl !== 0) begin
            bad++; $display("FAIL stall_stability: got %0d glitches want 0", gl);
        end
        exp_last = 1'b1;
    endtask

    task automatic test_reset_busy();
        int acc, lat, gid, st, gl, seen;
        logic [2*W-1:0] prod, want_prod;
        mult_d = 10;
        req0_a = W'($urandom); req0_b = W'($urandom); req0_valid = 1'b1;
        #1;
        total++;
        if (req0_ready !== 1'b1) begin
            bad++; $display("FAIL rstbusy_ready: got %b want 1", req0_ready);
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL rstbusy_in_busy: got %b want 1", busy); end
        rst = 1'b1;
        #1;
        total++;
        if ({busy, rsp0_valid, rsp1_valid, mult_start} !== 4'b0000) begin
            bad++; $display("FAIL rstbusy_abort: got %b want 0000",
                            {busy, rsp0_valid, rsp1_valid, mult_start});
        end
        @(negedge clk);
        rst = 1'b0;
        exp_last = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid || busy) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL rstbusy_no_response: got %0d active cycles want 0", seen);
        end
        mult_d = int'($urandom_range(1, 12));
        req1_a = W'($urandom); req1_b = W'($urandom); req1_valid = 1'b1;
        want_prod = mul(req1_a, req1_b);
        serve(1, acc, lat, prod, gid, st, gl);
        total++;
        if (acc !== 1 || prod !== want_prod || lat !== mult_d + 2) begin
            bad++; $display("FAIL rstbusy_recover: got acc=%0d prod=%0d lat=%0d want 1 %0d %0d",
                            acc, prod, lat, want_prod, mult_d + 2);
        end
        exp_last = 1'b1;
    endtask

    task automatic test_random();
        int acc, lat, gid, st, gl, want, stall;
        logic [2*W-1:0] prod, want_prod;
        for (int i = 0; i < 20; i++) begin
            if (!req0_valid && $urandom_range(0, 1) == 1) begin
                req0_a = W'($urandom); req0_b = W'($urandom); req0_valid = 1'b1;
            end
            if (!req1_valid && $urandom_range(0, 1) == 1) begin
                req1_a = W'($urandom); req1_b = W'($urandom); req1_valid = 1'b1;
            end
            if (!req0_valid && !req1_valid) begin
                req0_a = W'($urandom); req0_b = W'($urandom); req0_valid = 1'b1;
            end
            mult_d    = int'($urandom_range(1, 12));
            stall     = int'($urandom_range(0, 3));
            want      = pick(req0_valid, req1_valid);
            want_prod = (want == 0) ? mul(req0_a, req0_b) : mul(req1_a, req1_b);
            serve(stall, acc, lat, prod, gid, st, gl);
            total++;
            if (acc !== want || gid !== want) begin
                bad++; $display("FAIL rand_grant[%0d]: got acc=%0d gid=%0d want %0d", i, acc, gid, want);
            end
            total++;
            if (prod !== want_prod) begin
                bad++; $display("FAIL rand_product[%0d]: got %0d want %0d", i, prod, want_prod);
            end
            total++;
            if (lat !== mult_d + 2 || st !== 1 || gl !== 0) begin
                bad++; $display("FAIL rand_timing[%0d]: got lat=%0d starts=%0d glitches=%0d want %0d 1 0",
                                i, lat, st, gl, mult_d + 2);
            end
            exp_last = want[0];
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        total++;
        if (mult_timeout !== 1'b0) begin
            bad++; $display("FAIL rand_no_timeout: got %b want 0", mult_timeout);
        end
    endtask

`ifdef MULT_WATCHDOG_EN
    task automatic test_watchdog();
        int acc, lat, gid, st, gl;
        logic [2*W-1:0] prod, want_prod;
        // Done on the very cycle the limit is reached: done wins.
        mult_d = TO;
        req0_a = W'($urandom); req0_b = W'($urandom); req0_valid = 1'b1;
        want_prod = mul(req0_a, req0_b);
        serve(0, acc, lat, prod, gid, st, gl);
        total++;
        if (prod !== want_prod || mult_timeout !== 1'b0 || lat !== TO + 2) begin
            bad++; $display("FAIL wd_edge: got prod=%0d to=%b lat=%0d want %0d 0 %0d",
                            prod, mult_timeout, lat, want_prod, TO + 2);
        end
        mult_hang = 1'b1;
        req0_a = W'($urandom); req0_b = W'($urandom); req0_valid = 1'b1;
        serve(0, acc, lat, prod, gid, st, gl);
        total++;
        if (prod !== 16'd0 || mult_timeout !== 1'b1 || lat !== TO + 2) begin
            bad++; $display("FAIL wd_expire: got prod=%0d to=%b lat=%0d want 0 1 %0d",
                            prod, mult_timeout, lat, TO + 2);
        end
        mult_hang = 1'b0;
        mult_d = 5;
        req1_a = W'($urandom); req1_b = W'($urandom); req1_valid = 1'b1;
        want_prod = mul(req1_a, req1_b);
        serve(0, acc, lat, prod, gid, st, gl);
        total++;
        if (prod !== want_prod || mult_timeout !== 1'b1) begin
            bad++; $display("FAIL wd_sticky: got prod=%0d to=%b want %0d 1",
                            prod, mult_timeout, want_prod);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        test_reset();
        test_single();
        test_tie();
        test_alternate();
        test_stall();
        test_reset_busy();
        test_random();
`ifdef MULT_WATCHDOG_EN
        test_watchdog();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
